// File: rtl/fpu_pkg.sv
// Shared constants, op/error encodings and controller state for the vector FPU issue path.
package fpu_pkg;

   localparam int FPU_LANE_W = 16;
   localparam int FPU_LANES  = 16;
   localparam int FPU_DATA_W = FPU_LANES * FPU_LANE_W;

   typedef enum logic [1:0] {
      OP_VADD = 2'b00,
      OP_VDOT = 2'b01,
      OP_SMUL = 2'b10,
      OP_ILL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ERR_OK  = 2'b00,
      ERR_ILL = 2'b01,
      ERR_TMO = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/fpu_timeout_cnt.sv
// BUSY-cycle counter for the FPU issue controller; tc flags the last allowed cycle.
module fpu_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64,
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one vector FPU operation at a time: latch operands, hold a one-hot strobe
// until fpu_done or timeout, then present the result on a ready/valid response.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_BUSY | operands and one strobe held, waiting for fpu_done / timeout
// ST_RESP | rsp_valid high, rsp_* held until the consumer takes them
import fpu_pkg::*;

module fpu_issue_ctrl #(
   parameter int DATA_W         = FPU_DATA_W,
   parameter int LANE_W         = FPU_LANE_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_va,
   input  logic [DATA_W-1:0] req_vb,
   input  logic [LANE_W-1:0] req_sa,
   input  logic [LANE_W-1:0] req_sb,
   output logic [DATA_W-1:0] fpu_va,
   output logic [DATA_W-1:0] fpu_vb,
   output logic [LANE_W-1:0] fpu_sa,
   output logic [LANE_W-1:0] fpu_sb,
   output logic              fpu_vadd,
   output logic              fpu_vdot,
   output logic              fpu_smul,
   input  logic [DATA_W-1:0] fpu_vout,
   input  logic [LANE_W-1:0] fpu_sout,
   input  logic              fpu_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_vout,
   output logic [LANE_W-1:0] rsp_sout,
   output logic [1:0]        rsp_err
);

   state_e state_q, state_d;
   op_e    op;
   logic   accept, done_hit, tmo_hit, tc;

   assign op = op_e'(req_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      done_hit = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = (op == OP_ILL) ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            // done has priority over a timeout landing in the same cycle
            if (fpu_done) begin
               done_hit = 1'b1;
               state_d  = ST_RESP;
            end else if (tc) begin
               tmo_hit = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);

   fpu_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (state_q == ST_BUSY),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpu_va   <= '0;
         fpu_vb   <= '0;
         fpu_sa   <= '0;
         fpu_sb   <= '0;
         fpu_vadd <= 1'b0;
         fpu_vdot <= 1'b0;
         fpu_smul <= 1'b0;
         rsp_vout <= '0;
         rsp_sout <= '0;
         rsp_err  <= ERR_OK;
      end else begin
         if (accept) begin
            fpu_va   <= req_va;
            fpu_vb   <= req_vb;
            fpu_sa   <= req_sa;
            fpu_sb   <= req_sb;
            fpu_vadd <= (op == OP_VADD);
            fpu_vdot <= (op == OP_VDOT);
            fpu_smul <= (op == OP_SMUL);
            if (op == OP_ILL) begin
               rsp_vout <= '0;
               rsp_sout <= '0;
               rsp_err  <= ERR_ILL;
            end
         end
         if (done_hit || tmo_hit) begin
            fpu_vadd <= 1'b0;
            fpu_vdot <= 1'b0;
            fpu_smul <= 1'b0;
         end
         if (done_hit) begin
            rsp_vout <= fpu_vout;
            rsp_sout <= fpu_sout;
            rsp_err  <= ERR_OK;
         end else if (tmo_hit) begin
            rsp_vout <= '0;
            rsp_sout <= '0;
            rsp_err  <= ERR_TMO;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: each op type, illegal op, timeout boundary,
// response backpressure and asynchronous reset mid-operation.
module tb_fpu_issue_ctrl;

   localparam int DW  = 256;
   localparam int LW  = 16;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [DW-1:0] req_va = '0, req_vb = '0;
   logic [LW-1:0] req_sa = '0, req_sb = '0;
   logic [DW-1:0] fpu_va, fpu_vb;
   logic [LW-1:0] fpu_sa, fpu_sb;
   logic          fpu_vadd, fpu_vdot, fpu_smul;
   logic [DW-1:0] fpu_vout = '0;
   logic [LW-1:0] fpu_sout = '0;
   logic          fpu_done = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_vout;
   logic [LW-1:0] rsp_sout;
   logic [1:0]    rsp_err;

   int n_chk = 0;
   int n_fail = 0;

   fpu_issue_ctrl #(.DATA_W(DW), .LANE_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_va(req_va), .req_vb(req_vb), .req_sa(req_sa), .req_sb(req_sb),
      .fpu_va(fpu_va), .fpu_vb(fpu_vb), .fpu_sa(fpu_sa), .fpu_sb(fpu_sb),
      .fpu_vadd(fpu_vadd), .fpu_vdot(fpu_vdot), .fpu_smul(fpu_smul),
      .fpu_vout(fpu_vout), .fpu_sout(fpu_sout), .fpu_done(fpu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_vout(rsp_vout), .rsp_sout(rsp_sout), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [LW-1:0] sa, input logic [LW-1:0] sb);
      req_valid = 1'b1;
      req_op    = op;
      req_va    = va;
      req_vb    = vb;
      req_sa    = sa;
      req_sb    = sb;
      step();
      req_valid = 1'b0;
   endtask

   task automatic handshake();
      fpu_done  = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hs_rsp_valid", rsp_valid, 0);
      chk("hs_req_ready", req_ready, 1);
   endtask

   logic [DW-1:0] held;
   int            n;

   initial begin
      step();
      step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_fpu_va", fpu_va, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_req_ready", req_ready, 1);

      // VADD: done raised 3 cycles after the strobe rose
      issue(2'b00, {16{16'h3C00}}, {16{16'h4000}}, 16'h1111, 16'h2222);
      chk("vadd_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 3'b100);
      chk("vadd_fpu_va", fpu_va, {16{16'h3C00}});
      chk("vadd_fpu_vb", fpu_vb, {16{16'h4000}});
      chk("vadd_fpu_sb", fpu_sb, 16'h2222);
      chk("vadd_req_ready", req_ready, 0);
      step();
      step();
      step();
      chk("vadd_busy_c4_strobe", fpu_vadd, 1);
      chk("vadd_busy_c4_rsp_valid", rsp_valid, 0);
      fpu_done = 1'b1;
      fpu_vout = {16{16'h4200}};
      fpu_sout = 16'h0123;
      step();
      fpu_done = 1'b0;
      chk("vadd_rsp_valid", rsp_valid, 1);
      chk("vadd_strobe_clr", {fpu_vadd, fpu_vdot, fpu_smul}, 0);
      chk("vadd_rsp_vout", rsp_vout, {16{16'h4200}});
      chk("vadd_rsp_sout", rsp_sout, 16'h0123);
      chk("vadd_rsp_err", rsp_err, 2'b00);
      handshake();

      // VDOT with done in the first strobe cycle
      issue(2'b01, {16{16'h3800}}, {16{16'h3800}}, 16'h0, 16'h0);
      chk("vdot_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 3'b010);
      fpu_done = 1'b1;
      fpu_vout = {16{16'h5A5A}};
      fpu_sout = 16'h4800;
      step();
      fpu_done = 1'b0;
      chk("vdot_rsp_valid", rsp_valid, 1);
      chk("vdot_strobe_1cyc", fpu_vdot, 0);
      chk("vdot_rsp_sout", rsp_sout, 16'h4800);
      chk("vdot_rsp_vout", rsp_vout, {16{16'h5A5A}});
      chk("vdot_rsp_err", rsp_err, 2'b00);
      handshake();

      // illegal op: no strobe, immediate error response
      issue(2'b11, {16{16'hAAAA}}, {16{16'h5555}}, 16'h7, 16'h8);
      chk("ill_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 0);
      chk("ill_rsp_valid", rsp_valid, 1);
      chk("ill_rsp_err", rsp_err, 2'b01);
      chk("ill_rsp_vout", rsp_vout, 0);
      chk("ill_rsp_sout", rsp_sout, 0);
      handshake();

      // SMUL with done exactly on the last allowed BUSY cycle
      issue(2'b10, {16{16'h4400}}, '0, 16'h3C00, 16'h4000);
      chk("smul_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 3'b001);
      for (int i = 0; i < TMO - 1; i++) step();
      chk("smul_last_cycle_strobe", fpu_smul, 1);
      chk("smul_last_cycle_rsp_valid", rsp_valid, 0);
      fpu_done = 1'b1;
      fpu_vout = {16{16'h1234}};
      fpu_sout = 16'h4200;
      step();
      fpu_done = 1'b0;
      chk("edge_done_rsp_valid", rsp_valid, 1);
      chk("edge_done_rsp_err", rsp_err, 2'b00);
      chk("edge_done_rsp_vout", rsp_vout, {16{16'h1234}});
      handshake();

      // SMUL timeout: fpu_done never arrives
      fpu_vout = {16{16'hBEEF}};
      fpu_sout = 16'hBEEF;
      issue(2'b10, {16{16'h4400}}, '0, 16'h3C00, 16'h4000);
      n = 0;
      while (fpu_smul && n < 4 * TMO) begin
         n++;
         step();
      end
      chk("tmo_strobe_cycles", n, TMO);
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_rsp_err", rsp_err, 2'b10);
      chk("tmo_rsp_vout", rsp_vout, 0);
      chk("tmo_rsp_sout", rsp_sout, 0);
      handshake();

      // backpressure with spurious done pulses and a pending request
      issue(2'b00, {16{16'h3C00}}, {16{16'h3C00}}, 16'h0, 16'h0);
      fpu_done = 1'b1;
      fpu_vout = {16{16'h4000}};
      fpu_sout = 16'h0042;
      step();
      held = rsp_vout;
      chk("bp_first_vout", held, {16{16'h4000}});
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_va    = {16{16'hFFFF}};
      for (int i = 0; i < 10; i++) begin
         fpu_done = i[0];
         fpu_vout = {16{i[15:0]}};
         fpu_sout = 16'hF000 | i[15:0];
         step();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_rsp_vout", rsp_vout, held);
         chk("bp_rsp_sout", rsp_sout, 16'h0042);
         chk("bp_fpu_va", fpu_va, {16{16'h3C00}});
         chk("bp_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 0);
      end
      req_valid = 1'b0;
      handshake();

      // async reset while BUSY
      issue(2'b00, {16{16'h3C00}}, {16{16'h4000}}, 16'h0, 16'h0);
      step();
      chk("arst_pre_strobe", fpu_vadd, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_strobes", {fpu_vadd, fpu_vdot, fpu_smul}, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_fpu_va", fpu_va, 0);
      #4 rst_n = 1'b1;
      step();
      chk("arst_req_ready", req_ready, 1);
      chk("arst_no_rsp", rsp_valid, 0);
      issue(2'b00, {16{16'h3C00}}, {16{16'h4000}}, 16'h0, 16'h0);
      chk("arst_vadd_strobe", fpu_vadd, 1);
      fpu_done = 1'b1;
      fpu_vout = {16{16'h4200}};
      step();
      fpu_done = 1'b0;
      chk("arst_vadd_rsp_valid", rsp_valid, 1);
      chk("arst_vadd_rsp_vout", rsp_vout, {16{16'h4200}});
      chk("arst_vadd_rsp_err", rsp_err, 2'b00);
      handshake();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
